// File: rtl/xc_aesmix.sv
// xc_aesmix: AES MixColumns / InvMixColumns ISE unit, one 32-bit column per op.
// Build macro XC_AESMIX_RESULT_GATE_EN zeroes result whenever ready is low.
module xc_aesmix #(
  parameter logic FAST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte; a is the byte at the output's own position.
  function automatic logic [7:0] mix(
    input logic       e,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] a2, a4, a8, b2, b4, b8;
    logic [7:0] c2, c4, c8, d2, d4, d8;
    a2 = xt(a); a4 = xt(a2); a8 = xt(a4);
    b2 = xt(b); b4 = xt(b2); b8 = xt(b4);
    c2 = xt(c); c4 = xt(c2); c8 = xt(c4);
    d2 = xt(d); d4 = xt(d2); d8 = xt(d4);
    if (e)
      return a2 ^ b2 ^ b ^ c ^ d;
    return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b)
         ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
  endfunction

  // Gated so the multipliers stay quiet while idle.
  logic [3:0][7:0] b;
  assign b = {rs2[31:16], rs1[15:0]} & {32{valid}};

  logic unused_ops;
  assign unused_ops = ^{rs1[31:16], rs2[15:0]};

  logic        rdy;
  logic [31:0] res;

  if (FAST) begin : g_fast
    logic unused_seq;
    assign unused_seq = clock ^ reset ^ flush;
    assign rdy = valid;
    assign res = {
      mix(enc, b[3], b[0], b[1], b[2]),
      mix(enc, b[2], b[3], b[0], b[1]),
      mix(enc, b[1], b[2], b[3], b[0]),
      mix(enc, b[0], b[1], b[2], b[3])
    };
  end else begin : g_seq
    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
    state_t          state_q, state_d;
    logic [2:0][7:0] r_q, r_d;
    logic [1:0]      k;
    logic [7:0]      o;

    assign k = state_q;
    assign o = mix(enc, b[k], b[k + 2'd1],
                   b[k + 2'd2], b[k + 2'd3]);

    always_comb begin
      state_d = state_q;
      r_d     = r_q;
      if (flush) begin
        state_d = S0;
      end else if (valid) begin
        unique case (state_q)
          S0: begin r_d[0] = o; state_d = S1; end
          S1: begin r_d[1] = o; state_d = S2; end
          S2: begin r_d[2] = o; state_d = S3; end
          S3: state_d = S0;
          default: state_d = S0;
        endcase
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= S0;
        r_q     <= '0;
      end else begin
        state_q <= state_d;
        r_q     <= r_d;
      end
    end

    assign rdy = valid && (state_q == S3);
    assign res = {o, r_q[2], r_q[1], r_q[0]};
  end

  assign ready = rdy;
`ifdef XC_AESMIX_RESULT_GATE_EN
  assign result = rdy ? res : 32'h0;
`else
  assign result = res;
`endif

endmodule
